button_event_decoder: RTL and testbench

//  Consumer end of the button input chain. Takes the clean, debounced button level from the

---
 rtl/button_event_decoder.sv | 166 ++++++++++++++++
 tb/tb_button_event_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Turns a debounced button level into single-cycle user events (press,
//   release, long-press, auto-repeat) plus a held level. Every output is
//   registered, so there is no combinational path from any input to any output.
//
//   Ports
//     BtnEvt_CLOCK_50     in  system clock, rising edge
//     BtnEvt_Reset_InLow  in  synchronous reset, active low
//     BtnEvt_Level_In     in  debounced button level, already synchronous
//     BtnEvt_Enable_In    in  1: decode events, 0: suppress and lock out
//     BtnEvt_Press_Out    out one-cycle pulse on an accepted press
//     BtnEvt_Release_Out  out one-cycle pulse on release of an accepted press
//     BtnEvt_Long_Out     out one-cycle pulse when the hold reaches LONG_CYCLES
//     BtnEvt_Repeat_Out   out one-cycle pulse every REPEAT_CYCLES after Long
//     BtnEvt_Held_Out     out 1 while an accepted press is in progress
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   LOCKOUT | after reset/disable; waits for the button to be released
//   IDLE    | armed; the next press is accepted
//   HOLD    | accepted press, counting towards Long
//   REPEAT  | past Long, emitting Repeat every REPEAT_CYCLES
module button_event_decoder #(
  parameter logic PRESS_LEVEL   = 1'b1,
  parameter int   LONG_CYCLES   = 50000000,
  parameter int   REPEAT_CYCLES = 10000000,
  parameter bit   REPEAT_EN     = 1'b1,
  parameter int   CNT_W         = 26
) (
  input  logic BtnEvt_CLOCK_50,
  input  logic BtnEvt_Reset_InLow,
  input  logic BtnEvt_Level_In,
  input  logic BtnEvt_Enable_In,
  output logic BtnEvt_Press_Out,
  output logic BtnEvt_Release_Out,
  output logic BtnEvt_Long_Out,
  output logic BtnEvt_Repeat_Out,
  output logic BtnEvt_Held_Out
);

  typedef enum logic [1:0] {
    S_LOCKOUT = 2'd0,
    S_IDLE    = 2'd1,
    S_HOLD    = 2'd2,
    S_REPEAT  = 2'd3
  } state_t;

  // The press edge itself clears the counter, so Long fires one count early
  // relative to LONG_CYCLES-1 to land on edge t+LONG_CYCLES-1.
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 2);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_long_done, w_long_done_nxt;
  logic             r_press, r_release, r_long, r_repeat, r_held;
  logic             w_press_nxt, w_release_nxt, w_long_nxt, w_repeat_nxt, w_held_nxt;
  logic             w_pr;

  assign w_pr = (BtnEvt_Level_In == PRESS_LEVEL);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_long_done_nxt = r_long_done;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_long_nxt      = 1'b0;
    w_repeat_nxt    = 1'b0;
    w_held_nxt      = 1'b0;

    if (!BtnEvt_Enable_In) begin
      // Disable drops any press in progress silently: no Release.
      w_state_nxt     = S_LOCKOUT;
      w_cnt_nxt       = '0;
      w_long_done_nxt = 1'b0;
    end else begin
      case (r_state)
        S_LOCKOUT: begin
          w_cnt_nxt       = '0;
          w_long_done_nxt = 1'b0;
          if (!w_pr) w_state_nxt = S_IDLE;
        end
        S_IDLE: begin
          w_long_done_nxt = 1'b0;
          if (w_pr) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            w_press_nxt = 1'b1;
            w_held_nxt  = 1'b1;
          end
        end
        S_HOLD: begin
          if (!w_pr) begin
            w_state_nxt     = S_IDLE;
            w_cnt_nxt       = '0;
            w_long_done_nxt = 1'b0;
            w_release_nxt   = 1'b1;
          end else begin
            w_held_nxt = 1'b1;
            if (r_long_done) begin
              // Only reachable with REPEAT_EN=0: counter stays frozen.
              w_cnt_nxt = r_cnt;
            end else if (r_cnt == LONG_TC) begin
              w_long_nxt = 1'b1;
              w_cnt_nxt  = '0;
              if (REPEAT_EN) w_state_nxt     = S_REPEAT;
              else           w_long_done_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end
        end
        S_REPEAT: begin
          if (!w_pr) begin
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_release_nxt = 1'b1;
          end else begin
            w_held_nxt = 1'b1;
            if (r_cnt == REPEAT_TC) begin
              w_repeat_nxt = 1'b1;
              w_cnt_nxt    = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          w_state_nxt = S_LOCKOUT;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge BtnEvt_CLOCK_50) begin
    if (!BtnEvt_Reset_InLow) begin
      r_state     <= S_LOCKOUT;
      r_cnt       <= '0;
      r_long_done <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_long_done <= w_long_done_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
      r_repeat    <= w_repeat_nxt;
      r_held      <= w_held_nxt;
    end
  end

  assign BtnEvt_Press_Out   = r_press;
  assign BtnEvt_Release_Out = r_release;
  assign BtnEvt_Long_Out    = r_long;
  assign BtnEvt_Repeat_Out  = r_repeat;
  assign BtnEvt_Held_Out    = r_held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic level = 1'b0;
  logic en = 1'b1;
  logic o_press, o_release, o_long, o_repeat, o_held;

  int errors = 0;
  int checks = 0;

  button_event_decoder #(
    .PRESS_LEVEL(1'b1), .LONG_CYCLES(L), .REPEAT_CYCLES(R),
    .REPEAT_EN(1'b1), .CNT_W(26)
  ) dut (
    .BtnEvt_CLOCK_50   (clk),
    .BtnEvt_Reset_InLow(rst_b),
    .BtnEvt_Level_In   (level),
    .BtnEvt_Enable_In  (en),
    .BtnEvt_Press_Out  (o_press),
    .BtnEvt_Release_Out(o_release),
    .BtnEvt_Long_Out   (o_long),
    .BtnEvt_Repeat_Out (o_repeat),
    .BtnEvt_Held_Out   (o_held)
  );

  always #5 clk = ~clk;

  // Behavioural model: an accepted press is described by its age in edges
  // since the press edge; Long and Repeat follow from the age arithmetically.
  bit m_valid = 0;
  bit m_locked = 1;
  bit m_pressing = 0;
  int m_age = 0;
  logic [4:0] m_exp = 5'b0;  // {press, release, long, repeat, held}

  always @(posedge clk) begin
    m_exp = 5'b0;
    if (!rst_b) begin
      m_locked = 1; m_pressing = 0; m_valid = 1;
    end else if (!en) begin
      m_locked = 1; m_pressing = 0;
    end else if (m_locked) begin
      if (!level) m_locked = 0;
    end else if (!m_pressing) begin
      if (level) begin
        m_pressing = 1; m_age = 0; m_exp = 5'b10001;
      end
    end else if (!level) begin
      m_pressing = 0; m_exp = 5'b01000;
    end else begin
      m_age++;
      m_exp[0] = 1'b1;
      m_exp[2] = (m_age == L - 1);
      m_exp[1] = (m_age > L - 1) && (((m_age - (L - 1)) % R) == 0);
    end
  end

  wire [4:0] dut_vec = {o_press, o_release, o_long, o_repeat, o_held};

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (dut_vec !== m_exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t dut={p,r,l,rp,h}=%b expected=%b", $time, dut_vec, m_exp);
      end
    end
  end

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int quiet_bad;

  initial begin
    // 1: reset, then press.
    rst_b = 0; level = 0; en = 1;
    cyc(3);
    chk("reset_state", dut_vec, 5'b00000);
    rst_b = 1;
    cyc(2);
    level = 1;
    cyc(1);
    chk("t1_press", dut_vec, 5'b10001);
    // 2: keep holding through Long and three Repeats.
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (k == 7) chk("t2_long", dut_vec, 5'b00101);
      if (k == 11 || k == 15 || k == 19) chk("t2_repeat", dut_vec, 5'b00011);
      if (k == 8) chk("t2_quiet", dut_vec, 5'b00001);
      if (k == 20) level = 0;
    end
    cyc(1);
    chk("t2_release", dut_vec, 5'b01000);
    cyc(1);
    chk("t2_after", dut_vec, 5'b00000);

    // 3: release exactly on the Long edge.
    cyc(1);
    level = 1;
    cyc(1);
    chk("t3_press", dut_vec, 5'b10001);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      if (k == 6) level = 0;
    end
    cyc(1);
    chk("t3_release_not_long", dut_vec, 5'b01000);
    cyc(3);

    // 4: button held through reset.
    rst_b = 0; level = 1;
    cyc(2);
    rst_b = 1;
    quiet_bad = 0;
    for (int k = 0; k < 30; k++) begin
      cyc(1);
      if (dut_vec != 5'b0) quiet_bad++;
    end
    chk("t4_locked_quiet", 5'(quiet_bad), 5'd0);
    level = 0;
    cyc(1);
    level = 1;
    cyc(1);
    chk("t4_press", dut_vec, 5'b10001);

    // 5: disable while in REPEAT, re-enable while still held.
    for (int k = 1; k <= 9; k++) cyc(1);
    chk("t5_in_repeat", dut_vec, 5'b00001);
    en = 0;
    quiet_bad = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      if (dut_vec != 5'b0) quiet_bad++;
    end
    en = 1;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      if (dut_vec != 5'b0) quiet_bad++;
    end
    chk("t5_no_release_no_press", 5'(quiet_bad), 5'd0);
    level = 0;
    cyc(1);
    chk("t5_idle", dut_vec, 5'b00000);
    level = 1;
    cyc(1);
    chk("t5_press", dut_vec, 5'b10001);
    level = 0;
    cyc(1);
    chk("t5_release", dut_vec, 5'b01000);

    // Enable drop on the same edge as a release: no pulse at all.
    level = 1;
    cyc(2);
    level = 0; en = 0;
    cyc(1);
    chk("en_drop_release", dut_vec, 5'b00000);
    en = 1;
    cyc(2);

    // 6: reset during a press, then release reset with the button held.
    level = 1;
    cyc(1);
    chk("t6_press", dut_vec, 5'b10001);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      if (k == 4) rst_b = 0;
    end
    cyc(1);
    chk("t6_reset_clears", dut_vec, 5'b00000);
    rst_b = 1;
    quiet_bad = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (dut_vec != 5'b0) quiet_bad++;
    end
    chk("t6_no_press", 5'(quiet_bad), 5'd0);
    level = 0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
